// File: rtl/yari_mem_sram_ctrl_if.sv
// Core-side memory port of the yari SRAM controller: tagged single-word writes,
// tagged burst-read requests and the tagged read-return channel.
interface yari_mem_sram_ctrl_if;
  logic        mem_waitrequest;
  logic [1:0]  mem_id;
  logic [29:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [3:0]  mem_writedatamask;
  logic [31:0] mem_readdata;
  logic [1:0]  mem_readdataid;

  modport master (
    input  mem_waitrequest, mem_readdata, mem_readdataid,
    output mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
  );

  modport slave (
    output mem_waitrequest, mem_readdata, mem_readdataid,
    input  mem_id, mem_address, mem_read, mem_write, mem_writedata, mem_writedatamask
  );
endinterface

// File: rtl/yari_mem_sram_ctrl.sv
// SRAM controller: single-word masked writes, critical-word-first wrapped burst reads,
// and a tag pipeline that returns read data in order with the requester's id.
module yari_mem_sram_ctrl #(
  parameter int SRAM_AW    = 18,
  parameter int BURST_LOG2 = 2,
  parameter int READ_LAT   = 1
) (
  input  logic                clock,
  input  logic                rst,
  yari_mem_sram_ctrl_if.slave mem,
  output logic [SRAM_AW-1:0]  sram_addr,
  output logic                sram_we,
  output logic [3:0]          sram_be,
  output logic [31:0]         sram_wdata,
  input  logic [31:0]         sram_rdata,
  output logic                err
);

  localparam int PIPE = READ_LAT + 1;
  localparam logic [BURST_LOG2:0] BURST_CNT = (BURST_LOG2 + 1)'(1 << BURST_LOG2);
  localparam logic [BURST_LOG2:0] CNT_ONE   = (BURST_LOG2 + 1)'(1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } state_e;

  state_e                    state_q;
  logic [BURST_LOG2:0]       cnt_q;
  logic [SRAM_AW-1:0]        base_q;
  logic [1:0]                id_q;
  logic [PIPE-1:0]           pv_q;
  logic [PIPE-1:0][1:0]      pid_q;
  logic [SRAM_AW-1:0]        sram_addr_q;
  logic                      sram_we_q;
  logic [3:0]                sram_be_q;
  logic [31:0]               sram_wdata_q;
  logic [31:0]               rdata_q;
  logic [1:0]                rid_q;
  logic                      err_q;
  logic                      accept;
  logic [SRAM_AW-1:0]        req_addr;

  // Word i of a burst stays inside the aligned line that contains the base address.
  function automatic logic [SRAM_AW-1:0] wrap_addr(input logic [SRAM_AW-1:0] base,
                                                   input logic [BURST_LOG2:0]  idx);
    logic [BURST_LOG2-1:0] lo;
    lo = base[BURST_LOG2-1:0] + idx[BURST_LOG2-1:0];
    wrap_addr = {base[SRAM_AW-1:BURST_LOG2], lo};
  endfunction

  assign mem.mem_waitrequest = rst | (state_q != ST_IDLE);
  assign accept              = (mem.mem_read | mem.mem_write) & ~mem.mem_waitrequest;
  assign req_addr            = mem.mem_address[SRAM_AW-1:0];

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      id_q         <= 2'd0;
      pv_q         <= '0;
      pid_q        <= '0;
      sram_addr_q  <= '0;
      sram_we_q    <= 1'b0;
      sram_be_q    <= 4'd0;
      sram_wdata_q <= 32'd0;
      rdata_q      <= 32'd0;
      rid_q        <= 2'd0;
      err_q        <= 1'b0;
    end else begin
      sram_we_q         <= 1'b0;
      pv_q[PIPE-1:1]    <= pv_q[PIPE-2:0];
      pid_q[PIPE-1:1]   <= pid_q[PIPE-2:0];
      pv_q[0]           <= 1'b0;
      pid_q[0]          <= 2'd0;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            // A simultaneous read+write is a protocol error; the write wins.
            if (mem.mem_write) begin
              sram_we_q    <= 1'b1;
              sram_addr_q  <= req_addr;
              sram_be_q    <= mem.mem_writedatamask;
              sram_wdata_q <= mem.mem_writedata;
              if (mem.mem_read) begin
                err_q <= 1'b1;
              end
            end else begin
              state_q     <= ST_READ;
              base_q      <= req_addr;
              id_q        <= mem.mem_id;
              cnt_q       <= CNT_ONE;
              sram_addr_q <= req_addr;
              pv_q[0]     <= 1'b1;
              pid_q[0]    <= mem.mem_id;
              if (mem.mem_id == 2'd0) begin
                err_q <= 1'b1;
              end
            end
          end
        end
        ST_READ: begin
          if (cnt_q == BURST_CNT) begin
            state_q <= ST_IDLE;
          end else begin
            sram_addr_q <= wrap_addr(base_q, cnt_q);
            pv_q[0]     <= 1'b1;
            pid_q[0]    <= id_q;
            cnt_q       <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // Tag stage READ_LAT lines up with the SRAM data for the address it travelled with.
      if (pv_q[READ_LAT]) begin
        rid_q <= pid_q[READ_LAT];
        if (pid_q[READ_LAT] != 2'd0) begin
          rdata_q <= sram_rdata;
        end
      end else begin
        rid_q <= 2'd0;
      end
    end
  end

  assign mem.mem_readdata   = rdata_q;
  assign mem.mem_readdataid = rid_q;
  assign sram_addr          = sram_addr_q;
  assign sram_we            = sram_we_q;
  assign sram_be            = sram_be_q;
  assign sram_wdata         = sram_wdata_q;
  assign err                = err_q;

endmodule

// File: tb/tb_yari_mem_sram_ctrl.sv
// Self-checking bench for yari_mem_sram_ctrl: SRAM behavioural model, reference memory
// and an expected-return queue of (cycle, id, data) built from the burst rules.
module tb_yari_mem_sram_ctrl;
  localparam int AW    = 18;
  localparam int BL    = 2;
  localparam int RL    = 1;
  localparam int BURST = 4;

  logic          clock;
  logic          rst;
  logic [AW-1:0] sram_addr;
  logic          sram_we;
  logic [3:0]    sram_be;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;
  logic          err;

  yari_mem_sram_ctrl_if bus();

  yari_mem_sram_ctrl #(.SRAM_AW(AW), .BURST_LOG2(BL), .READ_LAT(RL)) dut (
    .clock      (clock),
    .rst        (rst),
    .mem        (bus),
    .sram_addr  (sram_addr),
    .sram_we    (sram_we),
    .sram_be    (sram_be),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .err        (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_pass   = 0;
  int n_checks = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    merge = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) merge[8*b +: 8] = nw[8*b +: 8];
  endfunction

  function automatic logic [31:0] pat(input int i);
    logic [7:0] v;
    v = 8'(i);
    pat = {16'hC0DE, v, ~v};
  endfunction

  // Synchronous SRAM model, READ_LAT cycles from address to data.
  logic [31:0] sram_mem [256];
  logic [31:0] rd_pipe  [4];
  initial for (int i = 0; i < 256; i++) sram_mem[i] <= pat(i);
  always @(posedge clock) begin
    if (sram_we) sram_mem[sram_addr[7:0]] <= merge(sram_mem[sram_addr[7:0]], sram_wdata, sram_be);
    rd_pipe[0] <= sram_mem[sram_addr[7:0]];
    for (int k = 1; k < 4; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign sram_rdata = rd_pipe[RL-1];

  // Reference memory and expected return stream.
  logic [31:0] ref_mem [256];
  typedef struct {
    int          cyc;
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  bit   mon_en = 1'b0;

  always @(negedge clock) begin
    if (mon_en) begin
      n_checks++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        if (bus.mem_readdataid !== exp_q[0].id || bus.mem_readdata !== exp_q[0].data)
          $display("FAIL ret_word @%0d: got id=%0d data=%h, want id=%0d data=%h",
                   cyc, bus.mem_readdataid, bus.mem_readdata, exp_q[0].id, exp_q[0].data);
        else n_pass++;
        void'(exp_q.pop_front());
      end else begin
        if (bus.mem_readdataid !== 2'd0)
          $display("FAIL ret_idle @%0d: got id=%0d, want 0", cyc, bus.mem_readdataid);
        else n_pass++;
      end
    end
  end

  // Present a request at a negedge, wait for acceptance, update the reference model.
  task automatic issue(input logic rd, input logic wr, input logic [1:0] id,
                       input logic [29:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, output int acc);
    logic [7:0] base;
    logic [7:0] wa;
    exp_t       e;
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_id = id;
    bus.mem_address = addr; bus.mem_writedata = wdata; bus.mem_writedatamask = mask;
    acc = -1;
    for (int w = 0; w < 64; w++) begin
      if (!bus.mem_waitrequest) begin
        acc = cyc + 1;
        break;
      end
      @(negedge clock);
    end
    if (acc >= 0) begin
      @(posedge clock);
      @(negedge clock);
    end
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    if (acc < 0) begin
      n_checks++;
      $display("FAIL accept_timeout: request never accepted, want accept within 64 cycles");
      return;
    end
    base = addr[7:0];
    if (wr) begin
      ref_mem[base] = merge(ref_mem[base], wdata, mask);
    end else if (rd && id != 2'd0) begin
      for (int i = 0; i < BURST; i++) begin
        wa = (base & 8'hFC) | ((base + 8'(i)) & 8'h03);
        e.cyc = acc + 1 + RL + i; e.id = id; e.data = ref_mem[wa];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic drain();
    for (int w = 0; w < 100 && exp_q.size() > 0; w++) @(negedge clock);
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d words outstanding, want 0", exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clock);
    n_checks++;
    if (bus.mem_waitrequest !== 1'b1 || bus.mem_readdataid !== 2'd0 || bus.mem_readdata !== 32'd0 ||
        sram_we !== 1'b0 || sram_be !== 4'd0 || sram_addr !== 18'd0 || sram_wdata !== 32'd0 ||
        err !== 1'b0)
      $display("FAIL reset_vals: wr=%b id=%0d rd=%h we=%b be=%h a=%h wd=%h err=%b, want 1,0,0,0,0,0,0,0",
               bus.mem_waitrequest, bus.mem_readdataid, bus.mem_readdata, sram_we, sram_be,
               sram_addr, sram_wdata, err);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_waitrequest !== 1'b0) $display("FAIL reset_release_wait: got %b want 0", bus.mem_waitrequest);
    else n_pass++;
    @(negedge clock);
    mon_en = 1'b1;
  endtask

  task automatic test_write();
    int a;
    issue(1'b0, 1'b1, 2'd1, 30'h10, 32'hDEADBEEF, 4'hF, a);
    n_checks++;
    if (sram_we !== 1'b1 || sram_addr !== 18'h10 || sram_be !== 4'hF || sram_wdata !== 32'hDEADBEEF)
      $display("FAIL write_issue: we=%b a=%h be=%h wd=%h, want 1 10 f deadbeef",
               sram_we, sram_addr, sram_be, sram_wdata);
    else n_pass++;
    @(negedge clock);
    n_checks++;
    if (sram_we !== 1'b0 || bus.mem_waitrequest !== 1'b0)
      $display("FAIL write_after: we=%b wait=%b, want 0 0", sram_we, bus.mem_waitrequest);
    else n_pass++;
  endtask

  task automatic test_read();
    int a;
    logic [17:0] exp_addr [4];
    exp_addr[0] = 18'h1E; exp_addr[1] = 18'h1F; exp_addr[2] = 18'h1C; exp_addr[3] = 18'h1D;
    issue(1'b1, 1'b0, 2'd2, 30'h1E, 32'd0, 4'd0, a);
    for (int i = 0; i < BURST; i++) begin
      if (i > 0) @(negedge clock);
      n_checks++;
      if (sram_addr !== exp_addr[i] || sram_we !== 1'b0 || bus.mem_waitrequest !== 1'b1)
        $display("FAIL read_addr%0d: a=%h we=%b wait=%b, want %h 0 1",
                 i, sram_addr, sram_we, bus.mem_waitrequest, exp_addr[i]);
      else n_pass++;
    end
    @(negedge clock);
    n_checks++;
    if (bus.mem_waitrequest !== 1'b0) $display("FAIL read_wait_end: got %b want 0", bus.mem_waitrequest);
    else n_pass++;
    drain();
  endtask

  task automatic test_coherence();
    int aw, ar, seen;
    issue(1'b0, 1'b1, 2'd1, 30'h20, 32'h11223344, 4'hF, aw);
    @(negedge clock);
    issue(1'b0, 1'b1, 2'd1, 30'h20, 32'hAABBCCDD, 4'h3, aw);
    issue(1'b1, 1'b0, 2'd1, 30'h20, 32'd0, 4'd0, ar);
    n_checks++;
    if (ar != aw + 1) $display("FAIL coh_accept: read accepted at %0d, want %0d", ar, aw + 1);
    else n_pass++;
    seen = 0;
    for (int w = 0; w < 20 && seen == 0; w++) begin
      @(negedge clock);
      if (bus.mem_readdataid !== 2'd0) seen = 1;
    end
    n_checks++;
    if (bus.mem_readdataid !== 2'd1 || bus.mem_readdata !== 32'h1122CCDD)
      $display("FAIL coh_word0: id=%0d data=%h, want 1 1122ccdd", bus.mem_readdataid, bus.mem_readdata);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    int a1, a2, w1, w2, w3;
    issue(1'b1, 1'b0, 2'd1, 30'h0, 32'd0, 4'd0, a1);
    issue(1'b1, 1'b0, 2'd2, 30'h8, 32'd0, 4'd0, a2);
    n_checks++;
    if (a2 != a1 + 5) $display("FAIL b2b_read_accept: got %0d want %0d", a2 - a1, 5);
    else n_pass++;
    issue(1'b0, 1'b1, 2'd1, 30'h60, 32'h01020304, 4'hF, w1);
    issue(1'b0, 1'b1, 2'd1, 30'h61, 32'h05060708, 4'h0, w2);
    issue(1'b0, 1'b1, 2'd1, 30'h62, 32'h090A0B0C, 4'h9, w3);
    n_checks++;
    if (w2 != w1 + 1 || w3 != w2 + 1)
      $display("FAIL b2b_write_accept: gaps %0d,%0d want 1,1", w2 - w1, w3 - w2);
    else n_pass++;
    issue(1'b1, 1'b0, 2'd2, 30'h61, 32'd0, 4'd0, a1);
    drain();
  endtask

  task automatic test_random();
    int a, kind, gap;
    logic [7:0]  a8;
    logic [11:0] hi;
    logic [1:0]  id;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 2);
      a8   = 8'($urandom_range(64, 255));
      hi   = 12'($urandom_range(0, 4095));
      id   = 2'($urandom_range(1, 2));
      if (kind == 0) issue(1'b1, 1'b0, id, {hi, 10'd0, a8}, 32'd0, 4'd0, a);
      else issue(1'b0, 1'b1, id, {hi, 10'd0, a8}, $urandom, 4'($urandom_range(0, 15)), a);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clock);
    end
    drain();
    n_checks++;
    if (err !== 1'b0) $display("FAIL random_err: got %b want 0", err);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int a;
    issue(1'b1, 1'b0, 2'd2, 30'h30, 32'd0, 4'd0, a);
    repeat (2) @(negedge clock);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    n_checks++;
    if (bus.mem_readdataid !== 2'd0 || bus.mem_waitrequest !== 1'b1 || sram_we !== 1'b0)
      $display("FAIL rst_mid: id=%0d wait=%b we=%b, want 0 1 0",
               bus.mem_readdataid, bus.mem_waitrequest, sram_we);
    else n_pass++;
    repeat (2) @(negedge clock);
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.mem_waitrequest !== 1'b0) $display("FAIL rst_mid_release: wait=%b want 0", bus.mem_waitrequest);
    else n_pass++;
    repeat (8) @(negedge clock);
    issue(1'b1, 1'b0, 2'd1, 30'h34, 32'd0, 4'd0, a);
    drain();
  endtask

  task automatic test_protocol_err();
    int a;
    issue(1'b1, 1'b1, 2'd1, 30'h5, 32'h0BADF00D, 4'hF, a);
    n_checks++;
    if (sram_we !== 1'b1 || sram_addr !== 18'h5 || err !== 1'b1 || bus.mem_waitrequest !== 1'b0)
      $display("FAIL err_rw: we=%b a=%h err=%b wait=%b, want 1 5 1 0",
               sram_we, sram_addr, err, bus.mem_waitrequest);
    else n_pass++;
    repeat (8) @(negedge clock);
    n_checks++;
    if (err !== 1'b1) $display("FAIL err_sticky: got %b want 1", err);
    else n_pass++;
    issue(1'b1, 1'b0, 2'd0, 30'h8, 32'd0, 4'd0, a);
    n_checks++;
    if (bus.mem_waitrequest !== 1'b1 || err !== 1'b1)
      $display("FAIL err_id0: wait=%b err=%b, want 1 1", bus.mem_waitrequest, err);
    else n_pass++;
    repeat (10) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    rst = 1'b0;
    #1;
    n_checks++;
    if (err !== 1'b0) $display("FAIL err_clear: got %b want 0", err);
    else n_pass++;
    @(negedge clock);
  endtask

  initial begin
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_id = 2'd0;
    bus.mem_address = 30'd0; bus.mem_writedata = 32'd0; bus.mem_writedatamask = 4'd0;
    for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
    test_reset();
    test_write();
    test_read();
    test_coherence();
    test_back_to_back();
    test_random();
    test_reset_mid_burst();
    test_protocol_err();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/yari_mem_sram_ctrl.md
Name: yari_mem_sram_ctrl

Overview:
- Memory-side controller downstream of the yari core's arbitrated memory port.
- Accepts tagged single-word writes and tagged burst reads (cache-line fills) from the core and drives a synchronous SRAM.
- Read data returns in critical-word-first order, tagged with the requester's id on mem_readdataid.
- Decouples the core from SRAM latency; sits between the core's mem_* port and the board SRAM.

Parameters:
- SRAM_AW, 18, SRAM word-address width; mem_address[SRAM_AW-1:0] used, upper bits ignored (alias).
- BURST_LOG2, 2, log2 of words returned per read (BURST = 4).
- READ_LAT, 1, SRAM cycles from sram_addr presented to sram_rdata valid (1..4).

Ports:
- clock  in  1  single clock, all logic posedge
- rst  in  1  asynchronous, active-high reset
- mem_waitrequest  out  1  request not accepted this cycle
- mem_id  in  2  requester tag (1 = DC, 2 = IC; 0 = reserved "no data")
- mem_address  in  30  word address
- mem_read  in  1  read burst request
- mem_write  in  1  single-word write request
- mem_writedata  in  32  write data
- mem_writedatamask  in  4  byte enables, bit i -> bits 8i+7:8i
- mem_readdata  out  32  returned read word
- mem_readdataid  out  2  tag of mem_readdata; 0 = no valid data
- sram_addr  out  SRAM_AW  SRAM word address
- sram_we  out  1  SRAM write strobe
- sram_be  out  4  SRAM byte enables
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid READ_LAT cycles after sram_addr
- err  out  1  sticky protocol-error flag

Behaviour:
- Reset (async): state IDLE; all tag-pipeline valids cleared.
  - Reset values: mem_readdataid=0, mem_readdata=0, sram_we=0, sram_be=0, sram_addr=0, sram_wdata=0, err=0.
  - mem_waitrequest = rst | (state != IDLE), combinational.
  - Reset mid-burst drops all in-flight data; no tagged word appears after reset releases.
- Accept: request accepted at edge T when (mem_read | mem_write) & ~mem_waitrequest.
- Write, accepted at T:
  - Cycle T+1: sram_we=1, sram_addr=mem_address[SRAM_AW-1:0], sram_be=mask, sram_wdata=data.
  - State stays IDLE, so back-to-back writes are accepted every cycle.
  - mask=0 still pulses sram_we with be=0.
- Read, accepted at T: latch id and base address; state READ.
  - Cycles T+1..T+BURST: sram_we=0; issue word i (i=0..BURST-1) at T+1+i.
  - Word i address = {base[SRAM_AW-1:BURST_LOG2], (base[BURST_LOG2-1:0]+i) mod BURST}, i.e. wrap within the aligned line.
  - State returns to IDLE at T+BURST+1; mem_waitrequest is high T+1..T+BURST.
- Return path:
  - READ_LAT+1-deep shift register carries (valid, id) alongside each issued address.
  - sram_rdata is registered into mem_readdata; word i appears with mem_readdataid=id at cycle T+2+READ_LAT+i, contiguous.
  - mem_readdataid=0 in every other cycle; mem_readdata holds its last value when id=0.
- Overlap:
  - A write or a new read may be accepted while a previous burst's data is still in the return pipeline.
  - Ordering is preserved (in-order SRAM).
  - A write issued at cycle n is visible to a read address issued at cycle n+1 or later; the SRAM is write-first coherent.
- Protocol errors, each setting err (sticky until rst):
  - mem_read & mem_write together: write performed, read ignored.
  - mem_read with mem_id=0: burst executed, data returned with tag 0 (invisible).
- No idle sram_addr requirement; sram_addr holds its last value when not issuing.

Test Plan:
- Write addr 0x10, data 0xDEADBEEF, mask 0xF accepted at T -> T+1: sram_we=1, sram_addr=0x10, sram_be=0xF, sram_wdata=0xDEADBEEF; T+2: sram_we=0; waitrequest stays 0.
- Read id=2 addr 0x1E, READ_LAT=1 -> sram_addr 0x1E,0x1F,0x1C,0x1D at T+1..T+4; mem_readdataid=2 at T+3..T+6 with matching SRAM contents; waitrequest high T+1..T+4, low T+5.
- Preload 0x11223344 at 0x20; write 0xAABBCCDD mask 0x3 to 0x20; read id=1 next accepted cycle -> first returned word = 0x1122CCDD, tag 1.
- Read id=1 addr 0x0 then read id=2 addr 0x8 held asserted -> second accepted at T+5; tag 1 at T+3..T+6, tag 2 at T+8..T+11, tag 0 at T+7.
- Assert rst at T+3 during read id=2 -> mem_readdataid=0 immediately and stays 0 after release; waitrequest=1 during rst; next read after release returns normally.
- mem_read=mem_write=1, id=1, addr 0x5 -> sram_we=1 at T+1, no tagged data returned, err=1 and held until rst.
